// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder
//  Function : Adds two WIDTH-bit operands one nibble per cycle using a 4-bit
//             carry-lookahead slice, with a valid/ready handshake on each side.
//  Option   : define NIBBLE_SERIAL_ADDER_SUB_EN to add a SUB input (A - B).
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int c_nib   = WIDTH / 4;
  localparam int c_idx_w = (c_nib > 1) ? $clog2(c_nib) : 1;
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_nib - 1);

  generate
    if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [c_idx_w-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               w_sub_in;
  logic [3:0]         w_a_nib;
  logic [3:0]         w_b_nib;
  logic [3:0]         w_g;
  logic [3:0]         w_p;
  logic [3:0]         w_c;
  logic               w_c4;
  logic [3:0]         w_sum;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // Subtraction inverts B on the fly; the +1 comes from the preloaded carry.
  assign w_a_nib = a_q[{idx_q, 2'b00} +: 4];
  assign w_b_nib = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
  assign w_g     = w_a_nib & w_b_nib;
  assign w_p     = w_a_nib ^ w_b_nib;

  assign w_c[0] = carry_q;
  assign w_c[1] = w_g[0] | (w_p[0] & carry_q);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & carry_q);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & carry_q);
  assign w_c4   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & carry_q);
  assign w_sum  = w_p ^ w_c;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    s_d         = s_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          sub_d      = w_sub_in;
          carry_d    = w_sub_in ? 1'b1 : c_in;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        s_d[{idx_q, 2'b00} +: 4] = w_sum;
        carry_d                  = w_c4;
        idx_d                    = idx_q + c_idx_w'(1);
        if (idx_q == c_last) begin
          // Carry into the MSB is the slice's internal carry into bit 3.
          c_out_d     = w_c4;
          ovf_d       = w_c[3] ^ w_c4;
          idx_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      s_q         <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_adder
//  Function : Randomized and directed checks of nibble_serial_adder against an
//             arithmetic reference model (WIDTH = 16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  nibble_serial_adder #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide arithmetic; subtraction is A + ~B + 1.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                       input logic msub, output logic [W-1:0] es, output logic ec,
                       output logic eo);
    logic [W:0]   full;
    logic [W-1:0] bop;
    bop  = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bop} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    es   = full[W-1:0];
    ec   = full[W];
    eo   = (ma[W-1] == bop[W-1]) && (es[W-1] != ma[W-1]);
  endtask

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tcin,
                         input logic tsub, input int hold, input bit inject);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           waited;
    model(ta, tb_op, tcin, tsub, es, ec, eo);
    waited = 0;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    check_eq("in_ready_before_accept", 32'(in_ready), 32'd1);
    a        = ta;
    b        = tb_op;
    c_in     = tcin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    sub      = tsub;
`endif
    in_valid = 1'b1;
    step();
    // Scramble inputs after acceptance; the result in flight must not change.
    in_valid = inject;
    a        = W'($urandom);
    b        = W'($urandom);
    c_in     = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    sub      = 1'($urandom);
`endif
    check_eq("in_ready_in_run", 32'(in_ready), 32'd0);
    for (int i = 1; i < NIB; i++) begin
      step();
      check_eq("out_valid_early", 32'(out_valid), 32'd0);
    end
    step();
    check_eq("out_valid_rise", 32'(out_valid), 32'd1);
    check_eq("sum", 32'(s), 32'(es));
    check_eq("c_out", 32'(c_out), 32'(ec));
    check_eq("ovf", 32'(ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("hold_out_valid", 32'(out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_sum", 32'(s), 32'(es));
      check_eq("hold_c_out", 32'(c_out), 32'(ec));
      check_eq("hold_ovf", 32'(ovf), 32'(eo));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("out_valid_drop", 32'(out_valid), 32'd0);
    check_eq("in_ready_return", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    repeat (2) step();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(s), 32'd0);
    check_eq("rst_c_out", 32'(c_out), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    step();

    run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_txn(16'h1234, 16'h4321, 1'b1, 1'b0, 0, 1'b0);
    run_txn(16'h8000, 16'h8000, 1'b1, 1'b0, 3, 1'b0);
    run_txn(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 2, 1'b1);

    // Abort in the middle of RUN.
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    c_in     = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_sum", 32'(s), 32'd0);
    check_eq("abort_c_out", 32'(c_out), 32'd0);
    check_eq("abort_ovf", 32'(ovf), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    run_txn(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    run_txn(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    run_txn(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
    run_txn(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
`endif

    for (int t = 0; t < 24; t++) begin
      logic         rsub;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      run_txn(W'($urandom), W'($urandom), 1'($urandom), rsub,
              int'($urandom_range(0, 3)), bit'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
